// File: rtl/m_div_sequencer.sv
// m_div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU controller using a restoring shift-subtract datapath.
// Optional result reuse of the last computed operands when DIV_RESULT_REUSE_EN is defined.
module m_div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            res_valid_o,
    output logic [XLEN-1:0] res_o
);
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo, dvs;
    logic            op_rem, q_neg, r_neg;
    logic            sgn, a_neg, b_neg, div_zero, ovf, accept, hit, ge;
    logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix, hit_q, hit_r;
    logic [XLEN:0]   rem_sh, rem_nx;
    assign req_ready_o = (state == IDLE) & ~flush_i;
    assign busy_o      = (state == CALC) | (state == FIX);
    assign res_valid_o = (state == DONE);
    assign accept      = req_valid_i & req_ready_o;
    assign sgn         = ~op_i[0];
    assign a_neg       = sgn & dividend_i[XLEN-1];
    assign b_neg       = sgn & divisor_i[XLEN-1];
    assign a_abs       = a_neg ? -dividend_i : dividend_i;
    assign b_abs       = b_neg ? -divisor_i : divisor_i;
    assign div_zero    = (divisor_i == '0);
    assign ovf         = sgn & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor_i);
    assign rem_sh      = {rem[XLEN-1:0], quo[XLEN-1]};
    assign ge          = rem_sh >= {1'b0, dvs};
    assign rem_nx      = ge ? rem_sh - {1'b0, dvs} : rem_sh;
    assign q_fix       = q_neg ? -quo : quo;
    assign r_fix       = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
`ifdef DIV_RESULT_REUSE_EN
    logic [XLEN-1:0] last_a, last_b;
    logic            last_u, reuse_vld;
    assign hit = reuse_vld & (dividend_i == last_a) & (divisor_i == last_b) & (op_i[0] == last_u);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reuse_vld <= 1'b0;
            last_a    <= '0;
            last_b    <= '0;
            last_u    <= 1'b0;
            hit_q     <= '0;
            hit_r     <= '0;
        end else if (flush_i) begin
            if (busy_o) reuse_vld <= 1'b0;
        end else if (state == FIX) begin
            reuse_vld <= 1'b1;
            hit_q     <= q_fix;
            hit_r     <= r_fix;
        end else if (accept & ~div_zero & ~ovf & ~hit) begin
            reuse_vld <= 1'b0;
            last_a    <= dividend_i;
            last_b    <= divisor_i;
            last_u    <= op_i[0];
        end
    end
`else
    assign hit   = 1'b0;
    assign hit_q = '0;
    assign hit_r = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            op_rem <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            res_o  <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_rem <= op_i[1];
                    if (div_zero) begin
                        res_o <= op_i[1] ? dividend_i : '1;
                        state <= DONE;
                    end else if (ovf) begin
                        res_o <= op_i[1] ? '0 : dividend_i;
                        state <= DONE;
                    end else if (hit) begin
                        res_o <= op_i[1] ? hit_r : hit_q;
                        state <= DONE;
                    end else begin
                        rem   <= '0;
                        quo   <= a_abs;
                        dvs   <= b_abs;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        cnt   <= CW'(XLEN - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= {quo[XLEN-2:0], ge};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    res_o <= op_rem ? r_fix : q_fix;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_div_sequencer.sv
// tb_m_div_sequencer: randomized and directed checks of m_div_sequencer against an arithmetic reference model.
module tb_m_div_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, flush = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        req_ready, busy, res_valid;
    logic [31:0] res;
    int          n_chk = 0, n_pass = 0;
    bit          rv = 0, lu = 0;
    logic [31:0] la = '0, lb = '0;
`ifdef DIV_RESULT_REUSE_EN
    localparam bit REUSE = 1;
`else
    localparam bit REUSE = 0;
`endif
    m_div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .op_i(op), .dividend_i(a), .divisor_i(b), .flush_i(flush),
        .busy_o(busy), .res_valid_o(res_valid), .res_o(res)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
        sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
        if (y == 0) begin
            q = -1;
            r = sx;
        end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = sx;
            r = 0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
        return o[1] ? r[31:0] : q[31:0];
    endfunction
    function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction
    task automatic accept_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 1, nb = 0, exp_lat;
        bit hit;
        hit = REUSE && rv && x == la && y == lb && o[0] == lu && !is_special(o, x, y);
        exp_lat = (is_special(o, x, y) || hit) ? 1 : 34;
        accept_op(o, x, y);
        @(negedge clk);
        while (!res_valid && n < 100) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, 64'(res), 64'(ref_div(o, x, y)));
        check({tag, "_busy"}, 64'(nb), 64'(exp_lat == 1 ? 0 : 33));
        if (!is_special(o, x, y) && !hit) begin
            rv = 1; la = x; lb = y; lu = o[0];
        end
    endtask
    initial begin
        logic [31:0] hold;
        #12;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op("divu", 2'b01, 32'd100, 32'd7);
        do_op("remu", 2'b11, 32'd100, 32'd7);
        do_op("div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op("remu_big", 2'b11, 32'hFFFF_FFF9, 32'd2);
        do_op("div_z", 2'b00, 32'd5, 32'd0);
        do_op("remu_z", 2'b11, 32'd5, 32'd0);
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_100_7", 2'b00, 32'd100, 32'd7);
        do_op("rem_100_7", 2'b10, 32'd100, 32'd7);
        hold = res;
        accept_op(2'b01, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1 check("flush_ready_gated", 64'(req_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        rv = 0;
        check("flush_valid", 64'(res_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_res_hold", 64'(res), 64'(hold));
        #1 check("flush_ready", 64'(req_ready), 64'd1);
        do_op("divu_9_3", 2'b01, 32'd9, 32'd3);
        accept_op(2'b00, 32'd12345, 32'd17);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        rv = 0;
        #1;
        check("arst_ready", 64'(req_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(res_valid), 64'd0);
        check("arst_res", 64'(res), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom_range(0, 1) ? $urandom : $urandom_range(1, 300);
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: if (rv) begin ra = la; rb = lb; end
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), ro, ra, rb);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
